// File: rtl/ram_mp_pkg.sv
// ram_mp_pkg: shared constants, clear-FSM encoding and byte parity helper for ram_multiport_clr
package ram_mp_pkg;
  localparam int RDW_READ_FIRST = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/ram_mp_rdport.sv
// ram_mp_rdport: one registered read port with read-during-write byte merge (parity check under RAM_PARITY_EN)
module ram_mp_rdport
  import ram_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RDW_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    hit,
  input  logic [DATA_WIDTH/8-1:0] w_be,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH-1:0]   mem_data,
`ifdef RAM_PARITY_EN
  input  logic                    inj_perr,
  input  logic [DATA_WIDTH/8-1:0] mem_par,
  output logic                    r_perr,
`endif
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    r_valid
);
  localparam int NB = DATA_WIDTH / 8;
  logic [NB-1:0] fwd;
  logic [DATA_WIDTH-1:0] word;
  // Only write-first mode forwards the bytes being written this edge
  assign fwd = (RDW_MODE == RDW_WRITE_FIRST && hit) ? w_be : '0;
  always_comb begin
    word = mem_data;
    for (int i = 0; i < NB; i++) word[8*i +: 8] = fwd[i] ? w_data[8*i +: 8] : mem_data[8*i +: 8];
  end
`ifdef RAM_PARITY_EN
  logic [NB-1:0] par, bad;
  always_comb begin
    par = mem_par;
    bad = '0;
    for (int i = 0; i < NB; i++) begin
      par[i] = fwd[i] ? even_par(w_data[8*i +: 8]) ^ inj_perr : mem_par[i];
      bad[i] = even_par(word[8*i +: 8]) != par[i];
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_valid <= 1'b0;
`ifdef RAM_PARITY_EN
      r_perr <= 1'b0;
`endif
    end else begin
      r_valid <= en;
      if (en) r_data <= word;
`ifdef RAM_PARITY_EN
      if (en) r_perr <= |bad;
`endif
    end
  end
endmodule

// File: rtl/ram_multiport_clr.sv
// ram_multiport_clr: byte-enable write port, NUM_RD registered read ports, post-reset clear sweep.
// Define RAM_PARITY_EN to store per-byte even parity and expose r_perr / inj_perr.
module ram_multiport_clr
  import ram_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_RD = 2,
  parameter int RDW_MODE = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [DATA_WIDTH/8-1:0]        w_be,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [NUM_RD-1:0]              r_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr,
`ifdef RAM_PARITY_EN
  input  logic                           inj_perr,
  output logic [NUM_RD-1:0]              r_perr,
`endif
  output logic [NUM_RD*DATA_WIDTH-1:0]   r_data,
  output logic [NUM_RD-1:0]              r_valid,
  output logic                           busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic run;
  assign run = state == ST_RUN;
  assign busy = !run;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      ptr <= '0;
    end else if (!run) begin
      ptr <= ptr + ADDR_WIDTH'(1);
      if (&ptr) state <= ST_RUN;
    end
  end
  // Writes arriving during the sweep are dropped, not queued
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) mem[ptr] <= '0;
      else if (we)
        for (int i = 0; i < NB; i++) if (w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
    end
  end
`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) par[ptr] <= '0;
      else if (we)
        for (int i = 0; i < NB; i++) if (w_be[i]) par[w_addr][i] <= even_par(w_data[8*i +: 8]) ^ inj_perr;
    end
  end
`endif
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    ram_mp_rdport #(.DATA_WIDTH(DATA_WIDTH), .RDW_MODE(RDW_MODE)) u_rd (
      .clk(clk),
      .rst(rst),
      .en(r_en[k] & run),
      .hit(we & run & (w_addr == a)),
      .w_be(w_be),
      .w_data(w_data),
      .mem_data(mem[a]),
`ifdef RAM_PARITY_EN
      .inj_perr(inj_perr),
      .mem_par(par[a]),
      .r_perr(r_perr[k]),
`endif
      .r_data(r_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .r_valid(r_valid[k])
    );
  end
endmodule

// File: tb/tb_ram_multiport_clr.sv
// tb_ram_multiport_clr: read-first and write-first instances checked against a behavioural memory model
module tb_ram_multiport_clr;
  localparam int AW = 3, DW = 16, NR = 3, NB = 2;
  logic clk = 0, rst = 1, we = 0;
  logic [NB-1:0] w_be = 0;
  logic [AW-1:0] w_addr = 0;
  logic [DW-1:0] w_data = 0;
  logic [NR-1:0] r_en = 0;
  logic [NR*AW-1:0] r_addr = 0;
  logic [NR*DW-1:0] rd0, rd1;
  logic [NR-1:0] rv0, rv1;
  logic busy0, busy1;
`ifdef RAM_PARITY_EN
  logic inj_perr = 0;
  logic [NR-1:0] pe0, pe1;
`endif
  always #5 clk = ~clk;

  ram_multiport_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .RDW_MODE(0)) u0 (
    .clk(clk), .rst(rst), .we(we), .w_be(w_be), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr),
`ifdef RAM_PARITY_EN
    .inj_perr(inj_perr), .r_perr(pe0),
`endif
    .r_data(rd0), .r_valid(rv0), .busy(busy0));
  ram_multiport_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .RDW_MODE(1)) u1 (
    .clk(clk), .rst(rst), .we(we), .w_be(w_be), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr),
`ifdef RAM_PARITY_EN
    .inj_perr(inj_perr), .r_perr(pe1),
`endif
    .r_data(rd1), .r_valid(rv1), .busy(busy1));

  int checks = 0, errors = 0;
  logic [DW-1:0] m [8];
  logic [NB-1:0] m_bad [8];
  int clr_left = 0;
  logic [DW-1:0] xd0 [NR], xd1 [NR];
  logic [NR-1:0] xv = 0, xp0 = 0, xp1 = 0;

  typedef struct {
    logic we; logic [1:0] be; logic [2:0] wa; logic [15:0] wd;
    logic [2:0] en; logic [8:0] ra;
    logic [2:0] ev; logic [47:0] e0, e1;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory as plain arrays: reset zeroes it at once, the sweep just blocks access for 8 cycles
  task automatic model_update();
    logic inj;
`ifdef RAM_PARITY_EN
    inj = inj_perr;
`else
    inj = 1'b0;
`endif
    if (rst) begin
      clr_left = 8;
      xv = '0; xp0 = '0; xp1 = '0;
      for (int k = 0; k < NR; k++) begin xd0[k] = '0; xd1[k] = '0; end
      for (int a = 0; a < 8; a++) begin m[a] = '0; m_bad[a] = '0; end
    end else if (clr_left > 0) begin
      clr_left--;
      xv = '0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        int a;
        logic [DW-1:0] nw;
        logic [NB-1:0] nb;
        a = int'(r_addr[k*AW +: AW]);
        nw = m[a];
        nb = m_bad[a];
        if (we && int'(w_addr) == a)
          for (int b = 0; b < NB; b++) if (w_be[b]) begin nw[8*b +: 8] = w_data[8*b +: 8]; nb[b] = inj; end
        xv[k] = r_en[k];
        if (r_en[k]) begin xd0[k] = m[a]; xd1[k] = nw; xp0[k] = |m_bad[a]; xp1[k] = |nb; end
      end
      if (we)
        for (int b = 0; b < NB; b++) if (w_be[b]) begin m[w_addr][8*b +: 8] = w_data[8*b +: 8]; m_bad[w_addr][b] = inj; end
    end
  endtask

  task automatic check_all();
    chk("busy0", 64'(busy0), 64'(clr_left > 0));
    chk("busy1", 64'(busy1), 64'(clr_left > 0));
    chk("valid0", 64'(rv0), 64'(xv));
    chk("valid1", 64'(rv1), 64'(xv));
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rdata0[%0d]", k), 64'(rd0[k*DW +: DW]), 64'(xd0[k]));
      chk($sformatf("rdata1[%0d]", k), 64'(rd1[k*DW +: DW]), 64'(xd1[k]));
`ifdef RAM_PARITY_EN
      if (xv[k]) begin
        chk($sformatf("perr0[%0d]", k), 64'(pe0[k]), 64'(xp0[k]));
        chk($sformatf("perr1[%0d]", k), 64'(pe1[k]), 64'(xp1[k]));
      end
`endif
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy0 && n < 20) begin
      tick();
      n++;
      chk({name, "_valid"}, 64'(rv0 | rv1), 64'd0);
    end
    chk({name, "_cycles"}, 64'(n), 64'd8);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'b11, 3'd5, 16'hABCD, 3'b000, 9'd0, 3'b000, 48'h0, 48'h0};
    vecs[1]  = '{1'b1, 2'b01, 3'd5, 16'h1234, 3'b000, 9'd0, 3'b000, 48'h0, 48'h0};
    vecs[2]  = '{1'b1, 2'b00, 3'd5, 16'hFFFF, 3'b001, 9'd5, 3'b001, 48'h0000_0000_AB34, 48'h0000_0000_AB34};
    vecs[3]  = '{1'b1, 2'b11, 3'd1, 16'h0011, 3'b000, 9'd0, 3'b000, 48'h0000_0000_AB34, 48'h0000_0000_AB34};
    vecs[4]  = '{1'b1, 2'b11, 3'd2, 16'h0022, 3'b000, 9'd0, 3'b000, 48'h0000_0000_AB34, 48'h0000_0000_AB34};
    vecs[5]  = '{1'b1, 2'b11, 3'd4, 16'h0055, 3'b000, 9'd0, 3'b000, 48'h0000_0000_AB34, 48'h0000_0000_AB34};
    vecs[6]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'b111, {3'd1, 3'd2, 3'd1}, 3'b111, 48'h0011_0022_0011, 48'h0011_0022_0011};
    vecs[7]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'b101, {3'd1, 3'd2, 3'd1}, 3'b101, 48'h0011_0022_0011, 48'h0011_0022_0011};
    vecs[8]  = '{1'b1, 2'b11, 3'd4, 16'h00AA, 3'b001, 9'd4, 3'b001, 48'h0011_0022_0055, 48'h0011_0022_00AA};
    vecs[9]  = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'b001, 9'd4, 3'b001, 48'h0011_0022_00AA, 48'h0011_0022_00AA};
    vecs[10] = '{1'b1, 2'b10, 3'd5, 16'h99EE, 3'b001, 9'd5, 3'b001, 48'h0011_0022_AB34, 48'h0011_0022_9934};
    vecs[11] = '{1'b0, 2'b00, 3'd0, 16'h0000, 3'b110, {3'd5, 3'd5, 3'd0}, 3'b110, 48'h9934_9934_AB34, 48'h9934_9934_9934};

    rst = 1; tick(); tick(); rst = 0;
    count_busy("clear");
    for (int a = 0; a < 8; a++) begin
      r_en = 3'b001; r_addr = 9'(a); tick();
      chk($sformatf("clr_rd%0d", a), 64'(rd0[15:0]), 64'd0);
      chk($sformatf("clr_v%0d", a), 64'(rv0[0]), 64'd1);
    end
    r_en = 0;

    for (int i = 0; i < 12; i++) begin
      we = vecs[i].we; w_be = vecs[i].be; w_addr = vecs[i].wa; w_data = vecs[i].wd;
      r_en = vecs[i].en; r_addr = vecs[i].ra;
      tick();
      chk($sformatf("vec%0d_v0", i), 64'(rv0), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_v1", i), 64'(rv1), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_d0", i), 64'(rd0), 64'(vecs[i].e0));
      chk($sformatf("vec%0d_d1", i), 64'(rd1), 64'(vecs[i].e1));
    end
    we = 0; r_en = 0;

    we = 1; w_be = 2'b11; w_addr = 3; w_data = 16'h0077; tick();
    we = 0; rst = 1; tick(); rst = 0;
    we = 1; w_addr = 3; w_data = 16'hFFFF; r_en = 3'b111; r_addr = {3'd3, 3'd3, 3'd3};
    count_busy("midrst");
    we = 0; tick();
    chk("addr3_after_clr0", 64'(rd0[15:0]), 64'd0);
    chk("addr3_after_clr1", 64'(rd1[15:0]), 64'd0);
    r_en = 0;
    rst = 1; tick(); rst = 0;
    repeat (4) tick();
    rst = 1; tick(); rst = 0;
    count_busy("restart");

`ifdef RAM_PARITY_EN
    we = 1; w_be = 2'b11; w_addr = 6; w_data = 16'h000F; inj_perr = 1; tick();
    we = 0; inj_perr = 0; r_en = 3'b001; r_addr = 9'd6; tick();
    chk("perr_inj", 64'(pe0[0] & rv0[0]), 64'd1);
    we = 1; r_en = 0; tick();
    we = 0; r_en = 3'b001; tick();
    chk("perr_clean", 64'(pe0[0]), 64'd0);
    r_en = 0;
`endif

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      we = 1'($urandom); w_be = NB'($urandom); w_addr = AW'($urandom); w_data = DW'($urandom);
      r_en = NR'($urandom); r_addr = (NR*AW)'($urandom);
      if ($urandom_range(0, 2) == 0) r_addr[AW-1:0] = w_addr;
`ifdef RAM_PARITY_EN
      inj_perr = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
